// File: rtl/nes_pad_reader_pkg.sv
// Shared NES pad definitions: button bit positions used by game logic,
// default pad timing and the reader FSM state encoding.
package NesPad;

    localparam int buttonA      = 0;
    localparam int buttonB      = 1;
    localparam int buttonSelect = 2;
    localparam int buttonStart  = 3;
    localparam int buttonUp     = 4;
    localparam int buttonDown   = 5;
    localparam int buttonLeft   = 6;
    localparam int buttonRight  = 7;

    localparam int buttonCount  = 8;
    localparam int lastBitIndex = buttonCount - 1;

    // ~12us latch and ~6us half bit at a 25.175MHz pixel clock
    localparam int defaultLatchCycles   = 302;
    localparam int defaultHalfBitCycles = 151;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        GAP      = 3'd2,
        CLK_HIGH = 3'd3,
        CLK_LOW  = 3'd4,
        DONE     = 3'd5
    } padState_t;

    // Wide enough to hold the longest phase length without wrapping.
    function automatic int counterWidth(int latchCycles, int halfBitCycles);
        int longest;
        longest = (latchCycles > halfBitCycles) ? latchCycles : halfBitCycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/nes_pad_reader_if.sv
// Signal bundle between the pad reader, the controller port and game logic.
// master = the reader; slave = the pad/game side that feeds and consumes it.
interface nes_pad_reader_if;

    logic       vSyncStart;
    logic       nesData;
    logic       nesLatch;
    logic       nesClock;
    logic [7:0] buttons;
    logic [7:0] buttonsPressed;
    logic       buttonsValid;
    logic       busy;

    modport master (
        input  vSyncStart,
        input  nesData,
        output nesLatch,
        output nesClock,
        output buttons,
        output buttonsPressed,
        output buttonsValid,
        output busy
    );

    modport slave (
        output vSyncStart,
        output nesData,
        input  nesLatch,
        input  nesClock,
        input  buttons,
        input  buttonsPressed,
        input  buttonsValid,
        input  busy
    );

endinterface

// File: rtl/nes_pad_reader_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a
// configurable reset value so idle lines come up in their inactive state.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic asyncIn,
    output logic syncOut
);

    logic meta;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta    <= RESET_VALUE;
            syncOut <= RESET_VALUE;
        end else begin
            meta    <= asyncIn;
            syncOut <= meta;
        end
    end

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller reader: once per frame latches the pad, clocks in 8 bits and
// publishes them as active-high buttons plus a newly-pressed mask.
module nes_pad_reader
    import NesPad::*;
#(
    parameter int LATCH_CYCLES    = defaultLatchCycles,
    parameter int HALF_BIT_CYCLES = defaultHalfBitCycles
) (
    input  logic             pixelClock,
    input  logic             reset,
    nes_pad_reader_if.master pad
);

    localparam int               CNT_W       = counterWidth(LATCH_CYCLES, HALF_BIT_CYCLES);
    localparam logic [CNT_W-1:0] latchLast   = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] halfBitLast = CNT_W'(HALF_BIT_CYCLES - 1);
    localparam logic [2:0]       finalBit    = 3'(lastBitIndex);

    padState_t        state, stateNext;
    logic [CNT_W-1:0] count, countNext, countStep;
    logic             countDone;
    logic [2:0]       bitIndex, bitIndexNext;
    logic [7:0]       shift, shiftNext;
    logic [7:0]       buttons, buttonsNext;
    logic [7:0]       pressed, pressedNext;
    logic             latchOut, clockOut, validOut, busyOut;
    logic             dataSync;

    // The data line idles high (pulled up), so the synchronizer resets to 1.
    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) dataSyncInst (
        .clock   (pixelClock),
        .reset   (reset),
        .asyncIn (pad.nesData),
        .syncOut (dataSync)
    );

    assign countDone = (state == LATCH) ? (count == latchLast) : (count == halfBitLast);
    assign countStep = countDone ? '0 : count + CNT_W'(1);

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        stateNext    = state;
        countNext    = count;
        bitIndexNext = bitIndex;
        shiftNext    = shift;
        buttonsNext  = buttons;
        pressedNext  = '0;

        unique case (state)
            IDLE: begin
                if (pad.vSyncStart) begin
                    stateNext    = LATCH;
                    countNext    = '0;
                    bitIndexNext = '0;
                end
            end
            LATCH: begin
                countNext = countStep;
                if (countDone) stateNext = GAP;
            end
            GAP: begin
                countNext = countStep;
                if (countDone) begin
                    shiftNext    = {dataSync, shift[7:1]};
                    bitIndexNext = 3'd1;
                    stateNext    = CLK_HIGH;
                end
            end
            CLK_HIGH: begin
                countNext = countStep;
                if (countDone) stateNext = CLK_LOW;
            end
            CLK_LOW: begin
                countNext = countStep;
                if (countDone) begin
                    shiftNext = {dataSync, shift[7:1]};
                    if (bitIndex == finalBit) begin
                        // The shift register holds raw active-low pad bits.
                        stateNext   = DONE;
                        buttonsNext = ~shiftNext;
                        pressedNext = ~shiftNext & ~buttons;
                    end else begin
                        bitIndexNext = bitIndex + 3'd1;
                        stateNext    = CLK_HIGH;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Pad-facing and strobe outputs are registered from the next state so the
    // off-chip latch/clock lines never carry decode glitches.
    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            bitIndex <= '0;
            shift    <= '1;
            buttons  <= '0;
            pressed  <= '0;
            latchOut <= 1'b0;
            clockOut <= 1'b0;
            validOut <= 1'b0;
            busyOut  <= 1'b0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            bitIndex <= bitIndexNext;
            shift    <= shiftNext;
            buttons  <= buttonsNext;
            pressed  <= pressedNext;
            latchOut <= (stateNext == LATCH);
            clockOut <= (stateNext == CLK_HIGH);
            validOut <= (stateNext == DONE);
            busyOut  <= (stateNext != IDLE);
        end
    end

    assign pad.nesLatch       = latchOut;
    assign pad.nesClock       = clockOut;
    assign pad.buttons        = buttons;
    assign pad.buttonsPressed = pressed;
    assign pad.buttonsValid   = validOut;
    assign pad.busy           = busyOut;

    latchClockExclusive: assert property (
        @(posedge pixelClock) disable iff (reset) !(latchOut && clockOut));

    validOnlyWhileBusy: assert property (
        @(posedge pixelClock) disable iff (reset) validOut |-> busyOut);

    pressedOnlyWhenValid: assert property (
        @(posedge pixelClock) disable iff (reset) !validOut |-> (pressed == '0));

endmodule
